btb_fetch_pc_gen: RTL and testbench

Pre-IF next-PC generator sitting directly upstream of the BTB predictor. It owns the fetch PC, drives it onto the BTB read port and the fetch path, and consumes the BTB's registered `hit`/target one cycle later. It steers the next fetch group to the predicted target, squashing the sequential group already issued. It also packs write-back branch resolutions into the BTB write bus.

---
 rtl/btb_fetch_pc_gen.sv | 152 +++++++++++++++
 tb/tb_btb_fetch_pc_gen.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_fetch_pc_gen.sv
// btb_fetch_pc_gen: two-stage next-PC generator in front of the BTB.
// F0 owns the fetch PC and drives the BTB read port; F1 presents the fetch
// packet and combines it with the BTB result that arrives one cycle later.
// A predicted-taken hit squashes the sequential group already sitting in F0.
// Write-back branch resolutions are packed into a registered BTB write bus.
//
// Handshake: the packet on fetch_pc_o is transferred to IF on every rising
// edge where fetch_valid_o and if_allowin_i are both high; while
// if_allowin_i is low the packet and its prediction are held unchanged.
module btb_fetch_pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h1c00_0000,
  parameter int          FETCH_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_allowin_i,
  input  logic        btb_hit_i,
  input  logic [31:0] btb_branch_pc_i,
  input  logic        wb_redirect_i,
  input  logic [31:0] wb_redirect_pc_i,
  input  logic        wb_br_valid_i,
  input  logic [31:0] wb_br_pc_i,
  input  logic        wb_br_taken_i,
  input  logic [31:0] wb_br_target_i,
  input  logic        wb_pred_taken_i,
  input  logic [31:0] wb_pred_pc_i,
  output logic [31:0] pc_o,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_pc_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_pc_o,
  output logic [62:0] btb_wbus_o,
  output logic [0:0]  dbg_state_o
);

  localparam logic [0:0]  ST_BOOT  = 1'b0;
  localparam logic [0:0]  ST_RUN   = 1'b1;
  localparam logic [31:0] FB       = 32'(FETCH_BYTES);
  localparam logic [31:0] FB_MASK  = ~(FB - 32'd1);

  logic [0:0]  state_q;
  logic [31:0] f0_pc;
  logic        f0_valid;
  logic [31:0] f1_pc;
  logic        f1_valid;
  logic        f1_fresh;
  logic        f1_hit_q;
  logic [31:0] f1_tgt_q;
  logic [62:0] wbus_q;

  logic        f1_go;
  logic        f0_go;
  logic        eff_hit;
  logic [31:0] eff_tgt;
  logic        squash;
  logic [31:0] seq_pc;
  logic        pred_taken;

  // Advance, effective BTB result, squash decision and sequential PC.
  always_comb begin
    f1_go      = f1_valid & if_allowin_i;
    f0_go      = f0_valid & (!f1_valid | f1_go);
    eff_hit    = f1_fresh ? btb_hit_i : f1_hit_q;
    eff_tgt    = f1_fresh ? btb_branch_pc_i : f1_tgt_q;
    // Only the live BTB result redirects; the held copy is for outputs only.
    squash     = f1_valid & f1_fresh & btb_hit_i;
    seq_pc     = (f0_pc & FB_MASK) + FB;
    pred_taken = f1_valid & eff_hit;
  end

  // BOOT lasts one cycle after reset, then RUN until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= ST_RUN;
  end

  // F0: redirect beats squash, squash beats the sequential step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f0_pc    <= RESET_PC;
      f0_valid <= 1'b0;
    end else if (wb_redirect_i) begin
      f0_pc    <= wb_redirect_pc_i;
      f0_valid <= 1'b1;
    end else if (state_q == ST_BOOT) begin
      f0_valid <= 1'b1;
    end else if (squash) begin
      f0_pc    <= btb_branch_pc_i;
      f0_valid <= 1'b1;
    end else if (f0_go) begin
      f0_pc    <= seq_pc;
    end
  end

  // F1: load from F0, drain to IF, or hold; fresh marks the BTB-result cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f1_pc    <= 32'h0;
      f1_valid <= 1'b0;
      f1_fresh <= 1'b0;
    end else if (wb_redirect_i) begin
      f1_valid <= 1'b0;
      f1_fresh <= 1'b0;
    end else if (f0_go && !squash) begin
      f1_pc    <= f0_pc;
      f1_valid <= 1'b1;
      f1_fresh <= 1'b1;
    end else if (f1_go) begin
      f1_valid <= 1'b0;
      f1_fresh <= 1'b0;
    end else begin
      f1_fresh <= 1'b0;
    end
  end

  // Keep the BTB result for a stalled F1 packet so its prediction stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f1_hit_q <= 1'b0;
      f1_tgt_q <= 32'h0;
    end else if (f1_fresh && !f1_go) begin
      f1_hit_q <= btb_hit_i;
      f1_tgt_q <= btb_branch_pc_i;
    end
  end

  // BTB update: allocate on a missed or wrong-target taken branch,
  // invalidate on a predicted-taken branch that fell through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbus_q <= 63'h0;
    end else if (wb_br_valid_i) begin
      if (wb_br_taken_i && (!wb_pred_taken_i || (wb_pred_pc_i != wb_br_target_i)))
        wbus_q <= {1'b1, 1'b1, wb_br_pc_i[9:3], wb_br_pc_i[31:10], wb_br_target_i};
      else if (!wb_br_taken_i && wb_pred_taken_i)
        wbus_q <= {1'b1, 1'b0, wb_br_pc_i[9:3], wb_br_pc_i[31:10], 32'h0};
      else
        wbus_q <= {1'b0, 1'b0, wb_br_pc_i[9:3], wb_br_pc_i[31:10], 32'h0};
    end else begin
      wbus_q <= 63'h0;
    end
  end

  assign pc_o          = f0_pc;
  assign fetch_valid_o = f1_valid;
  assign fetch_pc_o    = f1_pc;
  assign pred_taken_o  = pred_taken;
  assign pred_pc_o     = pred_taken ? eff_tgt : 32'h0;
  assign btb_wbus_o    = wbus_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_btb_fetch_pc_gen.sv
// Bench for btb_fetch_pc_gen: directed scenarios with literal expectations,
// a short randomised run, and a packet-level reference model compared on
// every negative clock edge.
module tb_btb_fetch_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_allowin_i;
  logic        btb_hit_i;
  logic [31:0] btb_branch_pc_i;
  logic        wb_redirect_i;
  logic [31:0] wb_redirect_pc_i;
  logic        wb_br_valid_i;
  logic [31:0] wb_br_pc_i;
  logic        wb_br_taken_i;
  logic [31:0] wb_br_target_i;
  logic        wb_pred_taken_i;
  logic [31:0] wb_pred_pc_i;
  logic [31:0] pc_o;
  logic        fetch_valid_o;
  logic [31:0] fetch_pc_o;
  logic        pred_taken_o;
  logic [31:0] pred_pc_o;
  logic [62:0] btb_wbus_o;
  logic [0:0]  dbg_state_o;

  btb_fetch_pc_gen dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_allowin_i     (if_allowin_i),
    .btb_hit_i        (btb_hit_i),
    .btb_branch_pc_i  (btb_branch_pc_i),
    .wb_redirect_i    (wb_redirect_i),
    .wb_redirect_pc_i (wb_redirect_pc_i),
    .wb_br_valid_i    (wb_br_valid_i),
    .wb_br_pc_i       (wb_br_pc_i),
    .wb_br_taken_i    (wb_br_taken_i),
    .wb_br_target_i   (wb_br_target_i),
    .wb_pred_taken_i  (wb_pred_taken_i),
    .wb_pred_pc_i     (wb_pred_pc_i),
    .pc_o             (pc_o),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_pc_o       (fetch_pc_o),
    .pred_taken_o     (pred_taken_o),
    .pred_pc_o        (pred_pc_o),
    .btb_wbus_o       (btb_wbus_o),
    .dbg_state_o      (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [62:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected write bus for one resolution, straight from the update rules.
  function automatic logic [62:0] exp_wbus(input logic v, input logic [31:0] pc,
                                           input logic taken, input logic [31:0] tgt,
                                           input logic ptaken, input logic [31:0] ppc);
    logic [6:0]  idx;
    logic [21:0] tag;
    idx = 7'((pc >> 3) % 32'd128);
    tag = 22'(pc >> 10);
    if (!v)                                  return 63'h0;
    if (taken && (!ptaken || ppc != tgt))    return {1'b1, 1'b1, idx, tag, tgt};
    if (!taken && ptaken)                    return {1'b1, 1'b0, idx, tag, 32'h0};
    return {1'b0, 1'b0, idx, tag, 32'h0};
  endfunction

  // ---------------- reference model ----------------
  // m_new marks a packet whose BTB answer is on the inputs this cycle;
  // afterwards its answer lives in m_hold_*.
  logic        m_boot;
  logic [31:0] m_f0_pc;
  logic        m_f0_v;
  logic [31:0] m_f1_pc;
  logic        m_f1_v;
  logic        m_new;
  logic        m_hold_hit;
  logic [31:0] m_hold_tgt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot     <= 1'b1;
      m_f0_pc    <= RESET_PC;
      m_f0_v     <= 1'b0;
      m_f1_pc    <= 32'h0;
      m_f1_v     <= 1'b0;
      m_new      <= 1'b0;
      m_hold_hit <= 1'b0;
      m_hold_tgt <= 32'h0;
      exp_q.delete();
    end else begin
      exp_q.push_back(exp_wbus(wb_br_valid_i, wb_br_pc_i, wb_br_taken_i,
                               wb_br_target_i, wb_pred_taken_i, wb_pred_pc_i));
      m_boot <= 1'b0;
      if (wb_redirect_i) begin
        m_f0_pc <= wb_redirect_pc_i;
        m_f0_v  <= 1'b1;
        m_f1_v  <= 1'b0;
        m_new   <= 1'b0;
      end else if (m_boot) begin
        m_f0_v <= 1'b1;
      end else if (m_f1_v && m_new && btb_hit_i) begin
        m_f0_pc <= btb_branch_pc_i;
        m_f0_v  <= 1'b1;
        m_new   <= 1'b0;
        if (if_allowin_i) m_f1_v <= 1'b0;
        else begin
          m_hold_hit <= 1'b1;
          m_hold_tgt <= btb_branch_pc_i;
        end
      end else if (m_f0_v && (!m_f1_v || if_allowin_i)) begin
        m_f1_pc <= m_f0_pc;
        m_f1_v  <= 1'b1;
        m_new   <= 1'b1;
        m_f0_pc <= m_f0_pc - (m_f0_pc % 32'd8) + 32'd8;
      end else if (m_f1_v && if_allowin_i) begin
        m_f1_v <= 1'b0;
        m_new  <= 1'b0;
      end else begin
        if (m_new) begin
          m_hold_hit <= btb_hit_i;
          m_hold_tgt <= btb_branch_pc_i;
        end
        m_new <= 1'b0;
      end
    end
  end

  // Compare every cycle, half a period after the active edge.
  always @(negedge clk) begin
    logic        e_hit;
    logic [31:0] e_tgt;
    logic [62:0] e_bus;
    e_hit = m_f1_v && (m_new ? btb_hit_i : m_hold_hit);
    e_tgt = m_new ? btb_branch_pc_i : m_hold_tgt;
    e_bus = (exp_q.size() > 0) ? exp_q.pop_front() : 63'h0;
    check("pc_o",          64'(pc_o),          64'(m_f0_pc));
    check("fetch_valid_o", 64'(fetch_valid_o), 64'(m_f1_v));
    check("fetch_pc_o",    64'(fetch_pc_o),    64'(m_f1_pc));
    check("pred_taken_o",  64'(pred_taken_o),  64'(e_hit));
    check("pred_pc_o",     64'(pred_pc_o),     64'(e_hit ? e_tgt : 32'h0));
    check("btb_wbus_o",    64'(btb_wbus_o),    64'(e_bus));
    check("dbg_state_o",   64'(dbg_state_o),   64'(!m_boot));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    if_allowin_i     = 1'b1;
    btb_hit_i        = 1'b0;
    btb_branch_pc_i  = 32'h0;
    wb_redirect_i    = 1'b0;
    wb_redirect_pc_i = 32'h0;
    wb_br_valid_i    = 1'b0;
    wb_br_pc_i       = 32'h0;
    wb_br_taken_i    = 1'b0;
    wb_br_target_i   = 32'h0;
    wb_pred_taken_i  = 1'b0;
    wb_pred_pc_i     = 32'h0;
  endtask

  task automatic drive_br(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                          input logic ptaken, input logic [31:0] ppc);
    wb_br_valid_i   = 1'b1;
    wb_br_pc_i      = pc;
    wb_br_taken_i   = taken;
    wb_br_target_i  = tgt;
    wb_pred_taken_i = ptaken;
    wb_pred_pc_i    = ppc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},    64'(pc_o),          64'(RESET_PC));
    check({tag, "_fv"},    64'(fetch_valid_o), 64'(0));
    check({tag, "_fpc"},   64'(fetch_pc_o),    64'(0));
    check({tag, "_pt"},    64'(pred_taken_o),  64'(0));
    check({tag, "_ppc"},   64'(pred_pc_o),     64'(0));
    check({tag, "_wbus"},  64'(btb_wbus_o),    64'(0));
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [62:0] lit_bus;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) step();
    #1;
    check_reset_outputs("rst");

    // Boot and sequential fetch.
    rst_n = 1'b1;
    step(); #1;
    check("boot_pc0", 64'(pc_o), 64'(32'h1c00_0000));
    check("boot_fv0", 64'(fetch_valid_o), 64'(0));
    step(); #1;
    check("first_fv",  64'(fetch_valid_o), 64'(1));
    check("first_fpc", 64'(fetch_pc_o), 64'(32'h1c00_0000));
    check("seq_pc1",   64'(pc_o), 64'(32'h1c00_0008));

    // Taken hit on 1c000008: target 1c000100 replaces 1c000010.
    step();
    btb_hit_i = 1'b1; btb_branch_pc_i = 32'h1c00_0100;
    #1;
    check("hit_fpc", 64'(fetch_pc_o), 64'(32'h1c00_0008));
    check("hit_pc",  64'(pc_o), 64'(32'h1c00_0010));
    check("hit_pt",  64'(pred_taken_o), 64'(1));
    check("hit_ppc", 64'(pred_pc_o), 64'(32'h1c00_0100));
    step();
    btb_hit_i = 1'b0; btb_branch_pc_i = 32'h0;
    #1;
    check("bubble_fv", 64'(fetch_valid_o), 64'(0));
    check("bubble_pc", 64'(pc_o), 64'(32'h1c00_0100));
    step();
    #1;
    check("tgt_fv",  64'(fetch_valid_o), 64'(1));
    check("tgt_fpc", 64'(fetch_pc_o), 64'(32'h1c00_0100));

    // Hit on 1c000100 (self-loop) while IF stalls for 3 cycles.
    btb_hit_i = 1'b1; btb_branch_pc_i = 32'h1c00_0100; if_allowin_i = 1'b0;
    #1;
    check("stall0_pt",  64'(pred_taken_o), 64'(1));
    check("stall0_ppc", 64'(pred_pc_o), 64'(32'h1c00_0100));
    step();
    btb_hit_i = 1'b0; btb_branch_pc_i = 32'h0;
    drive_br(32'h1c00_00f8, 1'b1, 32'h1c00_0200, 1'b0, 32'h0);
    #1;
    check("stall1_pt",  64'(pred_taken_o), 64'(1));
    check("stall1_ppc", 64'(pred_pc_o), 64'(32'h1c00_0100));
    check("stall1_pc",  64'(pc_o), 64'(32'h1c00_0100));
    step();
    wb_br_valid_i = 1'b0;
    #1;
    check("stall2_pt",  64'(pred_taken_o), 64'(1));
    check("stall2_ppc", 64'(pred_pc_o), 64'(32'h1c00_0100));
    check("stall2_pc",  64'(pc_o), 64'(32'h1c00_0100));
    check("stall2_fpc", 64'(fetch_pc_o), 64'(32'h1c00_0100));
    lit_bus = {1'b1, 1'b1, 7'h1f, 22'h070000, 32'h1c00_0200};
    check("pend_wbus", 64'(btb_wbus_o), 64'(lit_bus));

    // Asynchronous reset in the middle of the stall.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    clear_inputs();
    step(); step();
    rst_n = 1'b1;
    step();
    step();
    // Redirect collides with a BTB hit on the fresh packet.
    btb_hit_i = 1'b1; btb_branch_pc_i = 32'h1c00_0300;
    wb_redirect_i = 1'b1; wb_redirect_pc_i = 32'h1c00_0480;
    step();
    clear_inputs();
    #1;
    check("redir_pc", 64'(pc_o), 64'(32'h1c00_0480));
    check("redir_fv", 64'(fetch_valid_o), 64'(0));
    step();
    #1;
    check("redir_fpc", 64'(fetch_pc_o), 64'(32'h1c00_0480));

    // Back-to-back branch resolutions.
    drive_br(32'h1c00_00f8, 1'b1, 32'h1c00_0200, 1'b0, 32'h0);
    step();
    drive_br(32'h1c00_00f8, 1'b0, 32'h1c00_0200, 1'b1, 32'h1c00_0200);
    #1;
    lit_bus = {1'b1, 1'b1, 7'h1f, 22'h070000, 32'h1c00_0200};
    check("upd_alloc", 64'(btb_wbus_o), 64'(lit_bus));
    step();
    drive_br(32'h1c00_00f8, 1'b1, 32'h1c00_0200, 1'b1, 32'h1c00_0200);
    #1;
    lit_bus = {1'b1, 1'b0, 7'h1f, 22'h070000, 32'h0};
    check("upd_inval", 64'(btb_wbus_o), 64'(lit_bus));
    step();
    wb_br_valid_i = 1'b0;
    wb_redirect_i = 1'b1; wb_redirect_pc_i = 32'hffff_fffc;
    #1;
    check("upd_ok_we", 64'(btb_wbus_o[62]), 64'(0));

    // Wrap of the sequential adder.
    step();
    wb_redirect_i = 1'b0;
    #1;
    check("wrap_pc0", 64'(pc_o), 64'(32'hffff_fffc));
    step();
    #1;
    check("wrap_pc1", 64'(pc_o), 64'(32'h0000_0000));
    check("wrap_fpc", 64'(fetch_pc_o), 64'(32'hffff_fffc));

    // Randomised traffic checked by the model only.
    for (int i = 0; i < 400; i++) begin
      step();
      if_allowin_i     = ($urandom_range(0, 3) != 0);
      btb_hit_i        = ($urandom_range(0, 3) == 0);
      btb_branch_pc_i  = $urandom();
      wb_redirect_i    = ($urandom_range(0, 15) == 0);
      wb_redirect_pc_i = $urandom();
      wb_br_valid_i    = ($urandom_range(0, 1) == 1);
      wb_br_pc_i       = $urandom();
      wb_br_taken_i    = ($urandom_range(0, 1) == 1);
      wb_br_target_i   = $urandom();
      wb_pred_taken_i  = ($urandom_range(0, 1) == 1);
      wb_pred_pc_i     = ($urandom_range(0, 1) == 1) ? wb_br_target_i : $urandom();
    end
    step();
    clear_inputs();
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
